// File: rtl/wib_power_sequencer.sv
// Staggered 12 V WIB rail sequencer: one channel ramps at a time, per-channel
// filtered IV-alert fault latch, and on/fault status for the register block.
module wib_power_sequencer #(
  parameter int unsigned N_CH        = 6,
  parameter int unsigned STAGGER_CYC = 1000000,
  parameter int unsigned ALERT_FILT  = 16
) (
  input  logic            clk_axi,
  input  logic            rst_n,
  input  logic [N_CH-1:0] en_req,
  input  logic            fault_clr,
  input  logic [N_CH-1:0] alert_n,
  output logic [N_CH-1:0] vp12_en,
  output logic [N_CH-1:0] ch_on,
  output logic [N_CH-1:0] ch_fault,
  output logic            busy
);

  localparam int unsigned CW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam int unsigned FW = $clog2(ALERT_FILT + 1);
  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(STAGGER_CYC - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(ALERT_FILT);
  localparam logic [FW-1:0] FILT_LAST = FW'(ALERT_FILT - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   cur, cur_nxt;
  logic [N_CH-1:0] en_s1, en_s, al_s1, al_s;
  logic            fc_s1, fc_s, fc_d, clr_edge;
  logic [N_CH-1:0] en_q, en_nxt, fault_q, fault_nxt, fault_set;
  logic [N_CH-1:0] pending, start, cur_oh;
  logic [FW-1:0]   filt [N_CH];
  logic [FW-1:0]   filt_nxt [N_CH];
  logic            abort, found;

  always_ff @(posedge clk_axi or negedge rst_n) begin
    if (!rst_n) begin
      en_s1 <= '0;
      en_s  <= '0;
      al_s1 <= '1;
      al_s  <= '1;
      fc_s1 <= 1'b0;
      fc_s  <= 1'b0;
      fc_d  <= 1'b0;
    end else begin
      en_s1 <= en_req;
      en_s  <= en_s1;
      al_s1 <= alert_n;
      al_s  <= al_s1;
      fc_s1 <= fault_clr;
      fc_s  <= fc_s1;
      fc_d  <= fc_s;
    end
  end

  assign clr_edge = fc_s & ~fc_d;
  assign pending  = en_s & ~en_q & ~fault_q;
  assign busy     = (state == RAMP);
  assign cur_oh   = busy ? (N_CH'(1) << cur) : '0;

  // Filter counts only while the rail is driven; the fault fires on the edge
  // the count reaches ALERT_FILT.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      fault_set[i] = 1'b0;
      filt_nxt[i]  = '0;
      if (en_q[i] && !al_s[i]) begin
        fault_set[i] = (filt[i] == FILT_LAST);
        filt_nxt[i]  = (filt[i] == FILT_MAX) ? filt[i] : filt[i] + FW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur;
    start     = '0;
    found     = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (pending[i] && !found) begin
            found     = 1'b1;
            start[i]  = 1'b1;
            cur_nxt   = IW'(i);
          end
        end
        if (found) begin
          state_nxt = RAMP;
          cnt_nxt   = CNT_LOAD;
        end
      end
      RAMP: begin
        abort = ~|(cur_oh & en_s) | |(cur_oh & (fault_q | fault_set));
        if (abort) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    en_nxt    = (en_q & en_s & ~fault_set) | start;
    fault_nxt = (fault_q & ~{N_CH{clr_edge}}) | fault_set;
  end

  always_ff @(posedge clk_axi or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cur     <= '0;
      en_q    <= '0;
      fault_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) filt[i] <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur     <= cur_nxt;
      en_q    <= en_nxt;
      fault_q <= fault_nxt;
      for (int unsigned i = 0; i < N_CH; i++) filt[i] <= filt_nxt[i];
    end
  end

  assign vp12_en  = en_q;
  assign ch_fault = fault_q;
  assign ch_on    = en_q & ~cur_oh;

endmodule
